// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one unified instruction/data memory between the fetch
// port (IF) and the load/store port (D). The data port has priority, a
// saturating starvation counter guarantees forward progress for fetch, and a
// kill input discards the result of an in-flight fetch.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic              d_half,
  input  logic              d_zext,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic              mem_half,
  output logic              mem_zext,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             kill_pend;
  logic             if_ack_r;
  logic             starved;
  logic             grant_d;
  logic             grant_i;

  // Arbitration decision for the IDLE cycle: D wins unless fetch is starved.
  always_comb begin
    starved = if_req && (starve_cnt == STARVE_LIM);
    grant_d = d_req && !starved;
    grant_i = if_req && !grant_d;
  end

  // A kill arriving in the DONE cycle must still hide the already-registered
  // fetch ack, so the registered pulse is gated by the live kill input.
  assign if_ack = if_ack_r && !if_kill;

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      kill_pend  <= 1'b0;
      if_ack_r   <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_byte   <= 1'b0;
      mem_half   <= 1'b0;
      mem_zext   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_ack_r <= 1'b0;
      d_ack    <= 1'b0;
      case (state)
        IDLE: begin
          kill_pend <= 1'b0;
          if (grant_d) begin
            state     <= BUSY_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_byte  <= d_byte;
            mem_half  <= d_half;
            mem_zext  <= d_zext;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req)
              starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM
                                                       : starve_cnt + CNT_W'(1);
            else
              starve_cnt <= '0;
          end else if (grant_i) begin
            state      <= BUSY_I;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_byte   <= 1'b0;
            mem_half   <= 1'b0;
            mem_zext   <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        BUSY_I: begin
          if (if_kill)
            kill_pend <= 1'b1;
          if (mem_ack) begin
            mem_en <= 1'b0;
            state  <= DONE;
            if (!(kill_pend || if_kill)) begin
              if_rdata <= mem_rdata;
              if_ack_r <= 1'b1;
            end
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_en  <= 1'b0;
            d_rdata <= mem_rdata;
            d_ack   <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          state     <= IDLE;
          kill_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule
